// File: rtl/rv32_memory_arbiter.sv
// Two-port (core/aux) arbiter in front of a single-ported memory with 1-cycle read latency.
// Define RV32_MEM_ARB_RR_EN for round-robin tie-breaking; the default gives core fixed priority.
`timescale 1ns/1ps
module rv32_memory_arbiter #(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // Core port
  input  logic        core_req_i,
  input  logic [3:0]  core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_stall_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  // Aux port
  input  logic        aux_req_i,
  input  logic        aux_lock_i,
  input  logic [3:0]  aux_we_i,
  input  logic [31:0] aux_addr_i,
  input  logic [31:0] aux_wdata_i,
  output logic        aux_gnt_o,
  output logic        aux_rvalid_o,
  output logic [31:0] aux_rdata_o,
  // Memory port
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);
  localparam logic [CntW-1:0] LockMax = CntW'(MAX_LOCK);

  typedef enum logic [1:0] {StIdle, StCore, StAux, StAuxLocked} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic            rd_core_q, rd_aux_q;
  logic            gnt_core, gnt_aux;
  logic            core_wins;
  logic            locked;

`ifdef RV32_MEM_ARB_RR_EN
  logic last_aux_q;  // 1 when aux held the most recent grant
  assign core_wins = last_aux_q;
`else
  assign core_wins = 1'b1;
`endif

  assign locked = (state_q == StAuxLocked) && aux_req_i && aux_lock_i;

  always_comb begin
    gnt_core = 1'b0;
    gnt_aux  = 1'b0;
    if (!rst_n_i) begin
      gnt_core = 1'b0;
    end else if (locked) begin
      // Starvation guard: after MAX_LOCK locked grants a waiting core gets one slot
      if ((lock_cnt_q == LockMax) && core_req_i) begin
        gnt_core = 1'b1;
      end else begin
        gnt_aux = 1'b1;
      end
    end else if (core_req_i && aux_req_i) begin
      gnt_core = core_wins;
      gnt_aux  = ~core_wins;
    end else begin
      gnt_core = core_req_i;
      gnt_aux  = aux_req_i;
    end
  end

  always_comb begin
    state_d    = StIdle;
    lock_cnt_d = '0;
    if (gnt_core) begin
      state_d = StCore;
    end else if (gnt_aux && aux_lock_i) begin
      state_d    = StAuxLocked;
      lock_cnt_d = (lock_cnt_q == LockMax) ? lock_cnt_q : lock_cnt_q + CntW'(1);
    end else if (gnt_aux) begin
      state_d = StAux;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      lock_cnt_q <= '0;
      rd_core_q  <= 1'b0;
      rd_aux_q   <= 1'b0;
`ifdef RV32_MEM_ARB_RR_EN
      last_aux_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rd_core_q  <= gnt_core && (core_we_i == 4'h0);
      rd_aux_q   <= gnt_aux && (aux_we_i == 4'h0);
`ifdef RV32_MEM_ARB_RR_EN
      if (gnt_core) begin
        last_aux_q <= 1'b0;
      end else if (gnt_aux) begin
        last_aux_q <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (gnt_core) begin
      mem_en_o    = 1'b1;
      mem_we_o    = core_we_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end else if (gnt_aux) begin
      mem_en_o    = 1'b1;
      mem_we_o    = aux_we_i;
      mem_addr_o  = aux_addr_i;
      mem_wdata_o = aux_wdata_i;
    end
  end

  // Gating with rst_n_i keeps a read issued just before reset from surfacing
  assign core_gnt_o    = gnt_core;
  assign aux_gnt_o     = gnt_aux;
  assign core_stall_o  = rst_n_i & core_req_i & ~gnt_core;
  assign core_rvalid_o = rst_n_i & rd_core_q;
  assign aux_rvalid_o  = rst_n_i & rd_aux_q;
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : 32'h0;
  assign aux_rdata_o   = aux_rvalid_o ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_rv32_memory_arbiter.sv
// Table-driven bench for rv32_memory_arbiter with an rvalid scoreboard queue.
`timescale 1ns/1ps
module tb_rv32_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        core_req_i = 1'b0;
  logic [3:0]  core_we_i = 4'h0;
  logic [31:0] core_addr_i = 32'h0, core_wdata_i = 32'h0;
  logic        core_gnt_o, core_stall_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        aux_req_i = 1'b0, aux_lock_i = 1'b0;
  logic [3:0]  aux_we_i = 4'h0;
  logic [31:0] aux_addr_i = 32'h0, aux_wdata_i = 32'h0;
  logic        aux_gnt_o, aux_rvalid_o;
  logic [31:0] aux_rdata_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32_memory_arbiter #(.MAX_LOCK(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o), .core_stall_o(core_stall_o),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .aux_req_i(aux_req_i), .aux_lock_i(aux_lock_i), .aux_we_i(aux_we_i),
    .aux_addr_i(aux_addr_i), .aux_wdata_i(aux_wdata_i), .aux_gnt_o(aux_gnt_o),
    .aux_rvalid_o(aux_rvalid_o), .aux_rdata_o(aux_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic        rst_n;
    logic        core_req;
    logic [3:0]  core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        aux_req;
    logic        aux_lock;
    logic [3:0]  aux_we;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic [31:0] mem_rdata;
    logic        exp_cgnt;
    logic        exp_agnt;
  } vec_t;

  typedef struct {
    logic core_rv;
    logic aux_rv;
  } rv_t;

  rv_t  exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic cr, input logic [3:0] cwe, input logic [31:0] ca,
                              input logic ar, input logic al, input logic [3:0] awe,
                              input logic [31:0] aa, input logic [31:0] rd,
                              input logic ecg, input logic eag);
    vec_t v;
    v.rst_n = 1'b1;
    v.core_req = cr;  v.core_we = cwe; v.core_addr = ca; v.core_wdata = ca ^ 32'h1111_0000;
    v.aux_req = ar;   v.aux_lock = al; v.aux_we = awe;   v.aux_addr = aa;
    v.aux_wdata = aa ^ 32'h2222_0000;
    v.mem_rdata = rd; v.exp_cgnt = ecg; v.exp_agnt = eag;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    rv_t         e;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr, wdata;
    @(posedge clk);
    #1;
    rst_n_i = v.rst_n;
    core_req_i = v.core_req; core_we_i = v.core_we;
    core_addr_i = v.core_addr; core_wdata_i = v.core_wdata;
    aux_req_i = v.aux_req; aux_lock_i = v.aux_lock; aux_we_i = v.aux_we;
    aux_addr_i = v.aux_addr; aux_wdata_i = v.aux_wdata;
    mem_rdata_i = v.mem_rdata;
    #4;
    en    = v.exp_cgnt | v.exp_agnt;
    we    = v.exp_cgnt ? v.core_we : (v.exp_agnt ? v.aux_we : 4'h0);
    addr  = v.exp_cgnt ? v.core_addr : (v.exp_agnt ? v.aux_addr : 32'h0);
    wdata = v.exp_cgnt ? v.core_wdata : (v.exp_agnt ? v.aux_wdata : 32'h0);
    chk({tag, ".core_gnt"}, 32'(core_gnt_o), 32'(v.exp_cgnt));
    chk({tag, ".aux_gnt"}, 32'(aux_gnt_o), 32'(v.exp_agnt));
    chk({tag, ".stall"}, 32'(core_stall_o), 32'(v.rst_n & v.core_req & ~v.exp_cgnt));
    chk({tag, ".mem_en"}, 32'(mem_en_o), 32'(en));
    chk({tag, ".mem_we"}, 32'(mem_we_o), 32'(we));
    chk({tag, ".mem_addr"}, mem_addr_o, addr);
    chk({tag, ".mem_wdata"}, mem_wdata_o, wdata);
    e = '{1'b0, 1'b0};
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (!v.rst_n) e = '{1'b0, 1'b0};
    chk({tag, ".core_rvalid"}, 32'(core_rvalid_o), 32'(e.core_rv));
    chk({tag, ".aux_rvalid"}, 32'(aux_rvalid_o), 32'(e.aux_rv));
    chk({tag, ".core_rdata"}, core_rdata_o, e.core_rv ? v.mem_rdata : 32'h0);
    chk({tag, ".aux_rdata"}, aux_rdata_o, e.aux_rv ? v.mem_rdata : 32'h0);
    exp_q.push_back('{v.rst_n & v.exp_cgnt & (v.core_we == 4'h0),
                      v.rst_n & v.exp_agnt & (v.aux_we == 4'h0)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // Reset with both ports requesting: everything must stay quiet
    v = mk(1, 4'h0, 32'h100, 1, 1, 4'h0, 32'h40, 32'h1234_5678, 0, 0);
    v.rst_n = 1'b0;
    run(v, "rst0");
    run(v, "rst1");

    tbl.push_back(mk(0, 4'h0, 32'h0,   0, 0, 4'h0, 32'h0,  32'hA500_0000, 0, 0)); // 0 idle
    tbl.push_back(mk(1, 4'h0, 32'h100, 0, 0, 4'h0, 32'h0,  32'hA500_0001, 1, 0)); // 1 core rd
    tbl.push_back(mk(0, 4'h0, 32'h0,   1, 0, 4'h0, 32'h40, 32'hDEAD_BEEF, 0, 1)); // 2 aux rd
    tbl.push_back(mk(0, 4'h0, 32'h0,   0, 0, 4'h0, 32'h0,  32'hCAFE_F00D, 0, 0)); // 3
    v = mk(1, 4'hF, 32'h20, 0, 0, 4'h0, 32'h0, 32'hA500_0004, 1, 0);               // 4 core wr
    v.core_wdata = 32'h1234_5678;
    tbl.push_back(v);
    tbl.push_back(mk(0, 4'h0, 32'h0,   1, 0, 4'h3, 32'h44, 32'h0000_0055, 0, 1)); // 5 aux wr
`ifdef RV32_MEM_ARB_RR_EN
    tbl.push_back(mk(1, 4'h0, 32'h200, 1, 0, 4'h0, 32'h300, 32'hB000_0006, 1, 0));
    tbl.push_back(mk(1, 4'h0, 32'h204, 1, 0, 4'h0, 32'h304, 32'hB000_0007, 0, 1));
    tbl.push_back(mk(1, 4'h0, 32'h208, 1, 0, 4'h0, 32'h308, 32'hB000_0008, 1, 0));
    tbl.push_back(mk(1, 4'h0, 32'h20C, 1, 0, 4'h0, 32'h30C, 32'hB000_0009, 0, 1));
`else
    tbl.push_back(mk(1, 4'h0, 32'h200, 1, 0, 4'h0, 32'h300, 32'hB000_0006, 1, 0));
    tbl.push_back(mk(1, 4'h0, 32'h204, 1, 0, 4'h0, 32'h304, 32'hB000_0007, 1, 0));
    tbl.push_back(mk(1, 4'h0, 32'h208, 1, 0, 4'h0, 32'h308, 32'hB000_0008, 1, 0));
    tbl.push_back(mk(1, 4'h0, 32'h20C, 1, 0, 4'h0, 32'h30C, 32'hB000_0009, 1, 0));
`endif
    tbl.push_back(mk(0, 4'h0, 32'h0,   0, 0, 4'h0, 32'h0,   32'hB000_000A, 0, 0)); // 10
    // Lock: entry grant plus three more, then core breaks through, then aux resumes
    tbl.push_back(mk(0, 4'h0, 32'h0,   1, 1, 4'h0, 32'h400, 32'hC000_000B, 0, 1)); // 11
    tbl.push_back(mk(1, 4'h0, 32'h500, 1, 1, 4'h0, 32'h404, 32'hC000_000C, 0, 1)); // 12
    tbl.push_back(mk(1, 4'h0, 32'h500, 1, 1, 4'h0, 32'h408, 32'hC000_000D, 0, 1)); // 13
    tbl.push_back(mk(1, 4'h0, 32'h500, 1, 1, 4'h0, 32'h40C, 32'hC000_000E, 0, 1)); // 14
    tbl.push_back(mk(1, 4'h0, 32'h500, 1, 1, 4'h0, 32'h410, 32'hC000_000F, 1, 0)); // 15
    tbl.push_back(mk(0, 4'h0, 32'h0,   1, 1, 4'h0, 32'h414, 32'hC000_0010, 0, 1)); // 16
    tbl.push_back(mk(1, 4'h0, 32'h504, 1, 1, 4'h0, 32'h418, 32'hC000_0011, 0, 1)); // 17
    tbl.push_back(mk(1, 4'h0, 32'h504, 1, 1, 4'h0, 32'h41C, 32'hC000_0012, 0, 1)); // 18
    tbl.push_back(mk(1, 4'h0, 32'h504, 1, 1, 4'h0, 32'h420, 32'hC000_0013, 0, 1)); // 19
    tbl.push_back(mk(1, 4'h0, 32'h504, 1, 1, 4'h0, 32'h424, 32'hC000_0014, 1, 0)); // 20
    // Lock drop exits AUX_LOCKED with normal arbitration in the same cycle
    tbl.push_back(mk(0, 4'h0, 32'h0,   1, 1, 4'h0, 32'h428, 32'hC000_0015, 0, 1)); // 21
    tbl.push_back(mk(1, 4'h0, 32'h508, 1, 0, 4'h0, 32'h42C, 32'hC000_0016, 1, 0)); // 22
    // Lock without request must not block core
    tbl.push_back(mk(0, 4'h0, 32'h0,   1, 1, 4'h0, 32'h430, 32'hC000_0017, 0, 1)); // 23
    tbl.push_back(mk(1, 4'h0, 32'h50C, 0, 1, 4'h0, 32'h0,   32'hC000_0018, 1, 0)); // 24
    tbl.push_back(mk(0, 4'h0, 32'h0,   0, 0, 4'h0, 32'h0,   32'hC000_0019, 0, 0)); // 25

    foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));

    // Reset arriving while an aux read is in flight
    run(mk(0, 4'h0, 32'h0, 1, 0, 4'h0, 32'h80, 32'hD000_0000, 0, 1), "r_aux");
    v = mk(1, 4'h0, 32'h100, 1, 0, 4'h0, 32'h84, 32'hD000_0001, 0, 0);
    v.rst_n = 1'b0;
    run(v, "r_in0");
    v.mem_rdata = 32'hD000_0002;
    run(v, "r_in1");
    run(mk(1, 4'h0, 32'h180, 0, 0, 4'h0, 32'h0, 32'hD000_0003, 1, 0), "r_post");
    run(mk(0, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'hD000_0004, 0, 0), "r_post_rv");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_memory_arbiter.md
RV32_MEMORY_ARBITER -- requirements
Module: rv32_memory_arbiter

Interface
REQ-001 SHALL have parameter MAX_LOCK, default 4: maximum consecutive locked aux grants while core is waiting.
REQ-002 SHALL have ports `clk_i` (in, 1, sole clock) and `rst_n_i` (in, 1); reset is synchronous and active-low.
REQ-003 SHALL have core port inputs: core_req_i (1), core_we_i (4, byte write enables, 0 = read), core_addr_i (32), core_wdata_i (32).
REQ-004 SHALL have core port outputs: core_gnt_o (1), core_stall_o (1), core_rvalid_o (1), core_rdata_o (32).
REQ-005 SHALL have aux port inputs: aux_req_i (1), aux_lock_i (1), aux_we_i (4), aux_addr_i (32), aux_wdata_i (32).
REQ-006 SHALL have aux port outputs: aux_gnt_o (1), aux_rvalid_o (1), aux_rdata_o (32).
REQ-007 SHALL have memory port outputs mem_en_o (1), mem_we_o (4), mem_addr_o (32), mem_wdata_o (32), and input mem_rdata_i (32); the memory has a 1-cycle read latency.

Function
REQ-008 SHALL grant at most one port per cycle; gnt is combinational in the request cycle and means the access is accepted.
REQ-009 SHALL drive the mem_* outputs combinationally from the granted port; with no grant: mem_en_o=0, mem_we_o=0, addr/wdata=0.
REQ-010 SHALL assert the owner's rvalid exactly 1 cycle after a granted read (we==0), with rdata=mem_rdata_i; rdata SHALL be 0 when rvalid=0.
REQ-011 SHALL produce no rvalid for writes (we!=0).
REQ-012 SHALL drive core_stall_o = core_req_i & ~core_gnt_o.
REQ-013 SHALL implement FSM states IDLE, CORE, AUX, AUX_LOCKED, encoding the owner of the last cycle's grant.
REQ-014 SHALL, in IDLE/CORE/AUX, grant the sole requester; on a simultaneous request, select the winner per REQ-025/REQ-026.
REQ-015 SHALL go to AUX_LOCKED when aux is granted with aux_lock_i=1, and to AUX when aux is granted with aux_lock_i=0.
REQ-016 SHALL go to CORE on a core grant, and to IDLE on a cycle with no grant.
REQ-017 SHALL, in AUX_LOCKED, grant only aux while aux_req_i & aux_lock_i are high, and never grant core, except as in REQ-018.
REQ-018 SHALL keep lock_cnt, counting locked aux grants and saturating at MAX_LOCK; when lock_cnt==MAX_LOCK and core_req_i=1, core SHALL be granted, the state SHALL go to CORE, and lock_cnt SHALL clear.
REQ-019 SHALL clear lock_cnt on any exit from AUX_LOCKED: aux_req_i=0 or aux_lock_i=0, with arbitration per REQ-014 in that cycle.
REQ-020 SHALL not let aux_lock_i without aux_req_i block the core.
REQ-021 SHALL not affect rvalid routing with back-to-back grants to alternating ports; each rvalid goes to the port granted in the previous cycle.

Reset
REQ-022 SHALL, while rst_n_i=0 at a clk_i edge, set: state=IDLE, lock_cnt=0, pending-read owner cleared, last-owner=AUX.
REQ-023 SHALL hold all gnt/rvalid/stall/mem_en outputs at 0 and rdata at 0 during reset; an in-flight read at reset SHALL produce no rvalid afterwards.
REQ-024 SHALL arbitrate normally from the first cycle after rst_n_i rises.

Configuration
REQ-025 SHALL, when RV32_MEM_ARB_RR_EN is defined, resolve simultaneous requests outside AUX_LOCKED round-robin: the port not granted most recently wins, and the last-owner register updates on every grant.
REQ-026 SHALL, when RV32_MEM_ARB_RR_EN is undefined, resolve simultaneous requests outside AUX_LOCKED with fixed priority, core winning, and omit the last-owner register.

Verification
REQ-027 SHALL be verified: core read addr 0x100 alone, mem_rdata_i=0xDEADBEEF next cycle -> core_gnt_o=1 in cycle N, core_rvalid_o=1 with rdata 0xDEADBEEF in N+1.
REQ-028 SHALL be verified: both req every cycle for 4 cycles, macro off -> core granted 4/4 and core_stall_o=0; macro on -> grants C,A,C,A.
REQ-029 SHALL be verified: aux locked req continuous, core req from cycle 1, MAX_LOCK=4 -> 4 aux grants, then core granted, then aux resumes, lock_cnt=0.
REQ-030 SHALL be verified: core write we=0xF addr 0x20 wdata 0x12345678 -> mem_en_o=1, mem_we_o=0xF same cycle, no rvalid next cycle.
REQ-031 SHALL be verified: aux read granted, rst_n_i=0 next cycle -> aux_rvalid_o=0, all outputs 0, state IDLE; first post-reset core req granted immediately.
